sysctl_mtimer: RTL



---
 rtl/sysctl_mtimer_pkg.sv | 24 ++
 rtl/sysctl_mtimer_chan.sv | 82 ++++++++
 rtl/sysctl_mtimer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sysctl_mtimer_pkg.sv
// Shared constants for the multi-channel timer: register offsets,
// CTRL bit positions and the channel/global select bit.
package sysctl_mtimer_pkg;

    // csr_a bit that switches between channel and global registers
    localparam int GSEL_BIT = 9;

    // Channel register offsets (csr_a[2:0])
    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_COMPARE = 3'd1;
    localparam logic [2:0] REG_COUNTER = 3'd2;

    // Global register offsets (csr_a[1:0])
    localparam logic [1:0] REG_PENDING  = 2'd0;
    localparam logic [1:0] REG_MASK     = 2'd1;
    localparam logic [1:0] REG_PRESCALE = 2'd2;
    localparam logic [1:0] REG_CAPS     = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_PS = 2;

endpackage

// File: rtl/sysctl_mtimer_chan.sv
// One timer channel: control bits, up-counter, compare register and the
// step/match logic. match is a single-cycle pulse on the matching step.
module sysctl_mtimer_chan #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             ctrl_we,
    input  logic             cmp_we,
    input  logic             cnt_we,
    input  logic [width-1:0] wdata,
    output logic [2:0]       ctrl,
    output logic [width-1:0] compare,
    output logic [width-1:0] counter,
    output logic             match
);
    import sysctl_mtimer_pkg::*;

    logic             en_q, en_d;
    logic             ar_q, ar_d;
    logic             ps_q, ps_d;
    logic [width-1:0] counter_q, counter_d;
    logic [width-1:0] compare_q, compare_d;
    logic             step;

    assign step  = en_q & (~ps_q | tick);
    assign match = step & (counter_q == compare_q);

    // Hardware stepping first, then CSR writes override it
    always_comb begin
        en_d      = en_q;
        ar_d      = ar_q;
        ps_d      = ps_q;
        counter_d = counter_q;
        compare_d = compare_q;
        if (step) begin
            if (counter_q == compare_q) begin
                if (ar_q) counter_d = '0;
                else      en_d      = 1'b0;
            end else begin
                counter_d = counter_q + 1'b1;
            end
        end
        if (ctrl_we) begin
            en_d = wdata[CTRL_EN];
            ar_d = wdata[CTRL_AR];
            ps_d = wdata[CTRL_PS];
        end
        if (cnt_we) counter_d = wdata;
        if (cmp_we) compare_d = wdata;
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q      <= 1'b0;
            ar_q      <= 1'b0;
            ps_q      <= 1'b0;
            counter_q <= '0;
            compare_q <= '1;
        end else begin
            en_q      <= en_d;
            ar_q      <= ar_d;
            ps_q      <= ps_d;
            counter_q <= counter_d;
            compare_q <= compare_d;
        end
    end

    // Pack control bits for readback
    always_comb begin
        ctrl          = '0;
        ctrl[CTRL_EN] = en_q;
        ctrl[CTRL_AR] = ar_q;
        ctrl[CTRL_PS] = ps_q;
    end

    assign compare = compare_q;
    assign counter = counter_q;

endmodule

// File: rtl/sysctl_mtimer.sv
// Multi-channel timer CSR slave: shared prescaler, pending/mask registers,
// CSR decode and registered readback around ntimers channel instances.
module sysctl_mtimer #(
    parameter logic [4:0] csr_addr = 5'h0,
    parameter int         ntimers  = 4,
    parameter int         width    = 32,
    parameter int         pwidth   = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [14:0]        csr_a,
    input  logic               csr_we,
    input  logic [31:0]        csr_di,
    output logic [31:0]        csr_do,
    output logic [ntimers-1:0] timer_irq,
    output logic               irq
);
    import sysctl_mtimer_pkg::*;

    logic                           sel, wr, gwr, cwr;
    logic [2:0]                     chan_idx, reg_idx;
    logic                           pend_we, mask_we, presc_we, tick;
    logic [ntimers-1:0]             pending_q, pending_d;
    logic [ntimers-1:0]             mask_q, mask_d;
    logic [pwidth-1:0]              presc_reload_q, presc_reload_d;
    logic [pwidth-1:0]              presc_cnt_q, presc_cnt_d;
    logic [31:0]                    csr_do_q, csr_do_d, rdata;
    logic [ntimers-1:0]             match_v;
    logic [ntimers-1:0][2:0]        ctrl_v;
    logic [ntimers-1:0][width-1:0]  cmp_v, cnt_v;
    logic                           unused;

    assign sel      = (csr_a[14:10] == csr_addr);
    assign wr       = sel & csr_we;
    assign gwr      = wr & csr_a[GSEL_BIT];
    assign cwr      = wr & ~csr_a[GSEL_BIT];
    assign chan_idx = csr_a[5:3];
    assign reg_idx  = csr_a[2:0];
    assign pend_we  = gwr & (csr_a[1:0] == REG_PENDING);
    assign mask_we  = gwr & (csr_a[1:0] == REG_MASK);
    assign presc_we = gwr & (csr_a[1:0] == REG_PRESCALE);
    assign unused   = ^{csr_a[8:6], csr_di};

    // A PRESCALE write restarts the count and suppresses that cycle's tick
    assign tick = (presc_cnt_q == '0) & ~presc_we;

    // Channels; out-of-range channel indices never match a write strobe
    for (genvar g = 0; g < ntimers; g++) begin : g_chan
        logic hit;
        assign hit = cwr & (chan_idx == 3'(g));
        sysctl_mtimer_chan #(.width(width)) u_chan (
            .clk     (sys_clk),
            .rst_n   (sys_rst_n),
            .tick    (tick),
            .ctrl_we (hit & (reg_idx == REG_CTRL)),
            .cmp_we  (hit & (reg_idx == REG_COMPARE)),
            .cnt_we  (hit & (reg_idx == REG_COUNTER)),
            .wdata   (csr_di[width-1:0]),
            .ctrl    (ctrl_v[g]),
            .compare (cmp_v[g]),
            .counter (cnt_v[g]),
            .match   (match_v[g])
        );
    end

    // Next state for prescaler, pending (set beats W1C) and mask
    always_comb begin
        presc_reload_d = presc_reload_q;
        presc_cnt_d    = presc_cnt_q;
        if (presc_we) begin
            presc_reload_d = csr_di[pwidth-1:0];
            presc_cnt_d    = '0;
        end else if (presc_cnt_q == '0) begin
            presc_cnt_d = presc_reload_q;
        end else begin
            presc_cnt_d = presc_cnt_q - 1'b1;
        end
        pending_d = pending_q;
        if (pend_we) pending_d = pending_q & ~csr_di[ntimers-1:0];
        pending_d = pending_d | match_v;
        mask_d = mask_q;
        if (mask_we) mask_d = csr_di[ntimers-1:0];
    end

    // Read mux from current (pre-write) state
    always_comb begin
        rdata = '0;
        if (csr_a[GSEL_BIT]) begin
            case (csr_a[1:0])
                REG_PENDING:  rdata[ntimers-1:0] = pending_q;
                REG_MASK:     rdata[ntimers-1:0] = mask_q;
                REG_PRESCALE: rdata[pwidth-1:0]  = presc_reload_q;
                default:      rdata = {16'd0, 8'(width), 8'(ntimers)};
            endcase
        end else begin
            for (int i = 0; i < ntimers; i++) begin
                if (chan_idx == 3'(i)) begin
                    case (reg_idx)
                        REG_CTRL:    rdata[2:0] = ctrl_v[i];
                        REG_COMPARE: rdata = 32'(cmp_v[i]);
                        REG_COUNTER: rdata = 32'(cnt_v[i]);
                        default:     rdata = '0;
                    endcase
                end
            end
        end
        csr_do_d = sel ? rdata : 32'd0;
    end

    // Block-level registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            csr_do_q       <= '0;
            pending_q      <= '0;
            mask_q         <= '0;
            presc_reload_q <= '0;
            presc_cnt_q    <= '0;
        end else begin
            csr_do_q       <= csr_do_d;
            pending_q      <= pending_d;
            mask_q         <= mask_d;
            presc_reload_q <= presc_reload_d;
            presc_cnt_q    <= presc_cnt_d;
        end
    end

    assign csr_do    = csr_do_q;
    assign timer_irq = pending_q & mask_q;
    assign irq       = |timer_irq;

endmodule
